// File: rtl/acc_ctrl.sv
// Reduction controller: feeds the MAC its running partial sum, then holds the final result until the consumer is ready.
// Optional ACC_REQUANT_EN macro: rounds, shifts and saturates the result to int8 instead of passing it through raw.
`ifndef ACC_W
`define ACC_W 32
`endif

module acc_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [1:0]        i_mode,
  input  logic [4:0]        i_shift,
  input  logic              i_mac_valid,
  input  logic [`ACC_W-1:0] i_mac_result,
  output logic [`ACC_W-1:0] o_psum,
  output logic [1:0]        o_mode,
  output logic              o_busy,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [`ACC_W-1:0] o_out_data
);

  localparam int AW = `ACC_W;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [LEN_W-1:0]        len_r, cnt_r;
  logic [1:0]              mode_r;
  logic [4:0]              shift_r;
  logic signed [AW-1:0]    psum_r, out_data_r;
  logic                    start_ok, step, last_step;

  function automatic logic signed [AW-1:0] sat_int8(input logic signed [AW:0] q);
    if (q > (AW+1)'(127))       return AW'(127);
    else if (q < (AW+1)'(-128)) return AW'(-128);
    else                        return q[AW-1:0];
  endfunction

  // Half-LSB rounding before the arithmetic shift; one guard bit keeps the add from overflowing.
  function automatic logic signed [AW-1:0] requant(input logic signed [AW-1:0] v,
                                                   input logic [4:0] sh);
    logic signed [AW:0] ext, rnd, sum;
    ext = (AW+1)'(v);
    rnd = '0;
    if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
    sum = ext + rnd;
    return sat_int8(sum >>> sh);
  endfunction

  function automatic logic signed [AW-1:0] out_fn(input logic signed [AW-1:0] v,
                                                  input logic [4:0] sh);
`ifdef ACC_REQUANT_EN
    return requant(v, sh);
`else
    logic unused_sh;
    unused_sh = ^sh;
    return v;
`endif
  endfunction

  assign start_ok  = (state == IDLE) && i_start && (i_len != '0);
  assign step      = (state == ACC) && i_mac_valid;
  assign last_step = step && (cnt_r == len_r - LEN_W'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)    state_nxt = ACC;
      ACC:     if (last_step)   state_nxt = DRAIN;
      DRAIN:   if (i_out_ready) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (state != IDLE);
    o_out_valid = (state == DRAIN);
    o_psum      = (state == ACC) ? psum_r : '0;
    o_mode      = mode_r;
    o_out_data  = out_data_r;
  end

  // Fields are captured only on an accepted start, so starts during ACC/DRAIN cannot disturb them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      len_r      <= '0;
      cnt_r      <= '0;
      mode_r     <= '0;
      shift_r    <= '0;
      psum_r     <= '0;
      out_data_r <= '0;
    end else if (start_ok) begin
      len_r   <= i_len;
      mode_r  <= i_mode;
      shift_r <= i_shift;
      psum_r  <= '0;
      cnt_r   <= '0;
    end else if (step) begin
      psum_r <= i_mac_result;
      cnt_r  <= cnt_r + LEN_W'(1);
      if (last_step) out_data_r <= out_fn(i_mac_result, shift_r);
    end
  end

endmodule

// File: tb/tb_acc_ctrl.sv
// Directed bench for acc_ctrl: handshake, gaps, ignored starts, full-length count, async reset, optional requant.
`ifndef ACC_W
`define ACC_W 32
`endif

module tb_acc_ctrl;
  localparam int AW    = `ACC_W;
  localparam int LEN_W = 8;

  logic              i_clk = 1'b0;
  logic              i_rst, i_start, i_mac_valid, i_out_ready;
  logic [LEN_W-1:0]  i_len;
  logic [1:0]        i_mode;
  logic [4:0]        i_shift;
  logic [AW-1:0]     i_mac_result;
  logic [AW-1:0]     o_psum, o_out_data;
  logic [1:0]        o_mode;
  logic              o_busy, o_out_valid;

  int checks   = 0;
  int failures = 0;

  acc_ctrl #(.LEN_W(LEN_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len),
    .i_mode(i_mode), .i_shift(i_shift), .i_mac_valid(i_mac_valid),
    .i_mac_result(i_mac_result), .o_psum(o_psum), .o_mode(o_mode),
    .o_busy(o_busy), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_data(o_out_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [AW-1:0] obs, input int v);
    logic [AW-1:0] e;
    e = AW'(v);
    chk(tag, 64'(obs), 64'(e));
  endtask

  task automatic start(input int len, input int mode, input int sh);
    i_start = 1'b1;
    i_len   = LEN_W'(len);
    i_mode  = 2'(mode);
    i_shift = 5'(sh);
    tick();
    i_start = 1'b0;
  endtask

  task automatic mac(input int r);
    i_mac_valid  = 1'b1;
    i_mac_result = AW'(r);
    tick();
    i_mac_valid  = 1'b0;
  endtask

  task automatic drain();
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_len = '0; i_mode = '0; i_shift = '0;
    i_mac_valid = 1'b0; i_mac_result = '0; i_out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_valid", 64'(o_out_valid), 64'(0));
    chk_v("rst_psum", o_psum, 0);
    chk("rst_mode", 64'(o_mode), 64'(0));
    chk_v("rst_data", o_out_data, 0);
    i_rst = 1'b0;
    tick();

    // Basic three-step reduction with ready already high
    start(3, 2, 0);
    chk("b_busy", 64'(o_busy), 64'(1));
    chk("b_mode", 64'(o_mode), 64'(2));
    chk_v("b_psum0", o_psum, 0);
    mac(5);
    chk_v("b_psum1", o_psum, 5);
    mac(12);
    chk_v("b_psum2", o_psum, 12);
    chk("b_valid_early", 64'(o_out_valid), 64'(0));
    i_out_ready = 1'b1;
    mac(20);
    chk("b_valid", 64'(o_out_valid), 64'(1));
    chk_v("b_data", o_out_data, 20);
    chk_v("b_psum_drain", o_psum, 0);
    tick();
    i_out_ready = 1'b0;
    chk("b_valid_one", 64'(o_out_valid), 64'(0));
    chk("b_idle", 64'(o_busy), 64'(0));

    // Gaps in mac_valid and back-pressure on the output
    start(4, 1, 0);
    tick();
    chk_v("g_gap0", o_psum, 0);
    mac(7);
    chk_v("g_psum1", o_psum, 7);
    tick();
    chk_v("g_gap1", o_psum, 7);
    mac(9);
    mac(11);
    chk_v("g_psum3", o_psum, 11);
    tick();
    chk_v("g_gap2", o_psum, 11);
    mac(30);
    chk("g_valid", 64'(o_out_valid), 64'(1));
    i_mac_valid = 1'b1; i_mac_result = AW'(99);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("g_hold_valid", 64'(o_out_valid), 64'(1));
      chk_v("g_hold_data", o_out_data, 30);
    end
    i_mac_valid = 1'b0;
    // Start raised during the handshake cycle must not be taken until the next IDLE cycle
    i_start = 1'b1; i_len = LEN_W'(2); i_mode = 2'd3; i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    chk("g_idle", 64'(o_busy), 64'(0));
    chk("g_valid_low", 64'(o_out_valid), 64'(0));
    tick();
    i_start = 1'b0;
    chk("h_accept", 64'(o_busy), 64'(1));
    chk("h_mode", 64'(o_mode), 64'(3));
    mac(3);
    mac(4);
    chk_v("h_data", o_out_data, 4);
    drain();

    // Zero-length start ignored; start during ACC ignored
    start(0, 0, 0);
    chk("z_idle", 64'(o_busy), 64'(0));
    chk("z_mode", 64'(o_mode), 64'(3));
    start(2, 1, 0);
    chk("z_mode1", 64'(o_mode), 64'(1));
    start(9, 2, 0);
    chk("z_mode_kept", 64'(o_mode), 64'(1));
    mac(1);
    mac(2);
    chk("z_len_kept", 64'(o_out_valid), 64'(1));
    chk_v("z_data", o_out_data, 2);
    drain();

    // Maximum length completes without counter wrap
    start(255, 0, 0);
    for (int k = 0; k < 254; k++) mac(k);
    chk("m_not_done", 64'(o_out_valid), 64'(0));
    chk_v("m_psum", o_psum, 253);
    mac(100);
    chk("m_done", 64'(o_out_valid), 64'(1));
    chk_v("m_data", o_out_data, 100);
    drain();

    // Asynchronous reset mid-ACC and mid-DRAIN
    start(5, 2, 0);
    mac(10);
    mac(20);
    chk_v("r_psum", o_psum, 20);
    #2 i_rst = 1'b1;
    #1;
    chk("r_acc_busy", 64'(o_busy), 64'(0));
    chk_v("r_acc_psum", o_psum, 0);
    chk("r_acc_mode", 64'(o_mode), 64'(0));
    tick();
    i_rst = 1'b0;
    tick();
    chk("r_acc_idle", 64'(o_busy), 64'(0));
    start(1, 2, 0);
    chk("r_restart", 64'(o_busy), 64'(1));
    mac(42);
    chk_v("r_data", o_out_data, 42);
    #2 i_rst = 1'b1;
    #1;
    chk("r_dr_valid", 64'(o_out_valid), 64'(0));
    chk_v("r_dr_data", o_out_data, 0);
    chk("r_dr_busy", 64'(o_busy), 64'(0));
    tick();
    i_rst = 1'b0;
    tick();
    start(1, 1, 0);
    mac(-5);
    chk_v("r_neg", o_out_data, -5);
    drain();

`ifdef ACC_REQUANT_EN
    start(1, 0, 3); mac(1000);   chk_v("q_1000", o_out_data, 125);  drain();
    start(1, 0, 2); mac(5000);   chk_v("q_5000", o_out_data, 127);  drain();
    start(1, 0, 3); mac(-1000);  chk_v("q_m1000", o_out_data, -125); drain();
    start(1, 0, 0); mac(-70000); chk_v("q_m70000", o_out_data, -128); drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
